// File: rtl/multdiv_iter_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multdiv_iter_ctrl_pkg
// Shared definitions for the iterative multiply/divide unit: controller
// state encodings, operation codes and the default operand/counter widths.
// No ports (package).
// ---------------------------------------------------------------------------
package multdiv_iter_ctrl_pkg;

  // Default operand width and the matching iteration counter width.
  // The counter only has to hold WIDTH-1, so clog2(WIDTH) bits suffice.
  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_CNT_W = 5;

  // Controller states. The encodings are fixed so that a bus analyser or a
  // debug readout sees the same values across builds.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Operation latched at start time.
  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage

// File: rtl/multdiv_iter_ctrl_iter_down_counter.sv
// ---------------------------------------------------------------------------
// iter_down_counter
// Loadable down-counter that paces the iterative multiply/divide steps.
// Ports:
//   clock    - rising-edge clock
//   reset    - synchronous active-high reset, clears the count to 0
//   load     - load load_val (has priority over en)
//   load_val - value to load
//   en       - decrement by one
//   count    - current count
//   zero     - high while count is 0
// ---------------------------------------------------------------------------
module iter_down_counter
  import multdiv_iter_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  logic [CNT_W-1:0] r_count;

  // The count register. A load always wins over a decrement so the
  // controller can restart the sequence without first waiting for zero.
  // The controller stops enabling the counter once it reaches zero, so the
  // decrement never wraps.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign count = r_count;
  assign zero  = (r_count == '0);

endmodule

// File: rtl/multdiv_iter_ctrl.sv
// ---------------------------------------------------------------------------
// multdiv_iter_ctrl
// Iterative signed multiply/divide unit. A single-cycle ctrl_MULT/ctrl_DIV
// pulse in IDLE captures the operands; the unit then runs WIDTH shift-add
// (multiply) or restoring-divide steps on the operand magnitudes, applies
// the result sign in one FIX cycle and raises data_resultRDY for one cycle.
// Ports:
//   clock          - rising-edge clock
//   reset          - synchronous active-high reset, aborts any operation
//   ctrl_MULT      - start multiply (sampled only in IDLE, wins over DIV)
//   ctrl_DIV       - start divide (sampled only in IDLE)
//   data_operandA  - multiplicand / dividend, two's complement
//   data_operandB  - multiplier / divisor, two's complement
//   data_result    - product low word or quotient, held until next DONE
//   data_exception - multiply overflow, divide overflow or divide-by-zero
//   data_resultRDY - one-cycle result-valid strobe
//   busy           - high from the cycle after capture through the RDY cycle
// ---------------------------------------------------------------------------
module multdiv_iter_ctrl
  import multdiv_iter_ctrl_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t             r_state;
  state_t             w_nextState;
  op_t                r_op;
  logic               r_sign;
  logic [WIDTH-1:0]   r_absA;
  logic [WIDTH-1:0]   r_absB;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_result;
  logic               r_exception;

  logic               w_start;
  op_t                w_startOp;
  logic               w_divByZero;
  logic [WIDTH-1:0]   w_absA;
  logic [WIDTH-1:0]   w_absB;
  logic               w_cntLoad;
  logic               w_cntEn;
  logic [CNT_W-1:0]   w_count;
  logic               w_cntZero;
  logic [WIDTH:0]     w_mulSum;
  logic [WIDTH:0]     w_divTrial;
  logic [2*WIDTH-1:0] w_stepMul;
  logic [2*WIDTH-1:0] w_stepDiv;
  logic [2*WIDTH-1:0] w_signedProd;
  logic               w_mulOverflow;
  logic               w_divOverflow;

  // Start decode. Multiply takes priority when both pulses arrive together.
  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_startOp   = ctrl_MULT ? OP_MULT : OP_DIV;
  assign w_divByZero = (w_startOp == OP_DIV) && (data_operandB == '0);

  // Operand magnitudes. The most-negative value maps to 2^(WIDTH-1), which
  // still fits as an unsigned WIDTH-bit number.
  assign w_absA = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
  assign w_absB = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;

  // Multiply step on the {high, low} product pair: the multiplier sits in the
  // low half and is consumed from bit 0. The WIDTH+1-bit sum keeps the carry,
  // which becomes the new top bit after the right shift.
  assign w_mulSum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_absA} : '0);
  assign w_stepMul = {w_mulSum, r_prod[WIDTH-1:1]};

  // Restoring divide step on the {remainder, quotient} pair. The shifted
  // remainder is below 2*|B|, so the WIDTH+1-bit difference cannot overflow
  // and its top bit is a valid sign.
  assign w_divTrial = r_prod[2*WIDTH-1:WIDTH-1] - {1'b0, r_absB};
  assign w_stepDiv  = w_divTrial[WIDTH]
                    ? {r_prod[2*WIDTH-2:0], 1'b0}
                    : {w_divTrial[WIDTH-1:0], r_prod[WIDTH-2:0], 1'b1};

  // Sign fix-up shared by both operations: the low word of the negated
  // double-width value is also the negated quotient.
  assign w_signedProd  = r_sign ? (~r_prod + (2*WIDTH)'(1)) : r_prod;
  assign w_mulOverflow = (w_signedProd[2*WIDTH-1:WIDTH] != {WIDTH{w_signedProd[WIDTH-1]}});
  // A positive quotient with its top bit set only arises from
  // most-negative / -1; the low word is then the most-negative value.
  assign w_divOverflow = ~r_sign & r_prod[WIDTH-1];

  // Iteration counter: loaded with WIDTH-1 at start so that RUN spans
  // exactly WIDTH cycles, and held once it reaches zero.
  iter_down_counter #(
    .CNT_W (CNT_W)
  ) u_counter (
    .clock    (clock),
    .reset    (reset),
    .load     (w_cntLoad),
    .load_val (CNT_W'(WIDTH - 1)),
    .en       (w_cntEn),
    .count    (w_count),
    .zero     (w_cntZero)
  );

  // State register for the controller.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and control outputs. Start pulses are only looked at in IDLE,
  // so anything arriving while busy is simply dropped. Divide-by-zero skips
  // the iterations and reports straight away.
  always_comb begin
    w_nextState    = r_state;
    data_resultRDY = 1'b0;
    busy           = 1'b0;
    w_cntLoad      = 1'b0;
    w_cntEn        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_cntLoad   = 1'b1;
          w_nextState = w_divByZero ? DONE : RUN;
        end
      end
      RUN: begin
        busy    = 1'b1;
        w_cntEn = (w_count != '0);
        if (w_cntZero) begin
          w_nextState = FIX;
        end
      end
      FIX: begin
        busy        = 1'b1;
        w_nextState = DONE;
      end
      DONE: begin
        busy           = 1'b1;
        data_resultRDY = 1'b1;
        w_nextState    = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath registers. Capture happens in IDLE, one arithmetic step per RUN
  // cycle, and the visible result/exception only change on the edge that
  // enters DONE, so they hold steady between operations.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op        <= OP_MULT;
      r_sign      <= 1'b0;
      r_absA      <= '0;
      r_absB      <= '0;
      r_prod      <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_op   <= w_startOp;
            r_sign <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            r_absA <= w_absA;
            r_absB <= w_absB;
            r_prod <= (w_startOp == OP_MULT) ? {{WIDTH{1'b0}}, w_absB}
                                             : {{WIDTH{1'b0}}, w_absA};
            if (w_divByZero) begin
              r_result    <= '0;
              r_exception <= 1'b1;
            end
          end
        end
        RUN: begin
          r_prod <= (r_op == OP_MULT) ? w_stepMul : w_stepDiv;
        end
        FIX: begin
          r_result    <= w_signedProd[WIDTH-1:0];
          r_exception <= (r_op == OP_MULT) ? w_mulOverflow : w_divOverflow;
        end
        default: begin
        end
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;

endmodule

// File: tb/tb_multdiv_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multdiv_iter_ctrl
// Directed bench for multdiv_iter_ctrl (WIDTH=32). Expected values are
// hand-computed constants. Latency is counted in clock edges after the
// start edge: a normal operation shows RDY after edge WIDTH+1 (so it is
// sampled high by edge WIDTH+2), divide-by-zero right after the start edge.
// ---------------------------------------------------------------------------
module tb_multdiv_iter_ctrl;

  localparam int W = 32;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int nCompared   = 0;
  int nMismatched = 0;

  multdiv_iter_ctrl #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  // One comparison: count it, and on a miss count and report it.
  task automatic checkOutput(input string tag, input logic [W-1:0] observed,
                             input logic [W-1:0] expected);
    nCompared++;
    assert (observed === expected)
    else begin
      nMismatched++;
      $error("[TB] FAIL %s: observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present a start pulse for exactly one edge; returns #1 after that edge.
  task automatic applyStimulus(input logic mult, input logic div,
                               input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT     = mult;
    ctrl_DIV      = div;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Count edges until RDY is seen, bounded by maxCycles.
  task automatic waitRdy(input int maxCycles, output int cycles);
    cycles = 0;
    while (!data_resultRDY && cycles < maxCycles) begin
      @(posedge clock);
      #1;
      cycles++;
    end
  endtask

  // Count RDY strobes over a window of n edges.
  task automatic countRdy(input int n, output int cnt);
    cnt = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
  endtask

  // Full operation: start, latency, result, exception, then RDY drops and
  // busy clears on the following edge.
  task automatic runOp(input string tag, input logic mult, input logic div,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] expResult, input logic expExc,
                       input int expLatency);
    int lat;
    applyStimulus(mult, div, a, b);
    checkOutput({tag, " busy"}, W'(busy), 32'd1);
    waitRdy(60, lat);
    checkOutput({tag, " latency"}, W'(lat), W'(expLatency));
    checkOutput({tag, " result"}, data_result, expResult);
    checkOutput({tag, " exception"}, W'(data_exception), W'(expExc));
    @(posedge clock);
    #1;
    checkOutput({tag, " rdy drop"}, W'(data_resultRDY), 32'd0);
    checkOutput({tag, " busy drop"}, W'(busy), 32'd0);
  endtask

  initial begin
    int lat;
    int nRdy;

    // Reset held for two edges, everything must read zero.
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset result", data_result, 32'd0);
    checkOutput("reset exception", W'(data_exception), 32'd0);
    checkOutput("reset rdy", W'(data_resultRDY), 32'd0);
    checkOutput("reset busy", W'(busy), 32'd0);
    reset = 1'b0;

    // Multiplies: 6 * -7 = -42; 2^16 * 2^16 overflows with low word 0;
    // most-negative * 1 stays representable.
    runOp("mul 6x-7", 1'b1, 1'b0, 32'd6, 32'hFFFF_FFF9, 32'hFFFF_FFD6, 1'b0, 33);
    runOp("mul ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33);
    runOp("mul minx1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0, 33);

    // Divides: -43 / 5 truncates to -8; most-negative / -1 overflows.
    runOp("div -43/5", 1'b0, 1'b1, 32'hFFFF_FFD5, 32'd5, 32'hFFFF_FFF8, 1'b0, 33);
    runOp("div min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33);

    // Divide by zero reports right after the start edge.
    runOp("div by 0", 1'b0, 1'b1, 32'd7, 32'd0, 32'd0, 1'b1, 0);

    // Both ctrls at start (multiply wins), plus a DIV pulse mid-run that
    // must be ignored: one RDY only, with the product 12.
    applyStimulus(1'b1, 1'b1, 32'd3, 32'd4);
    repeat (10) @(posedge clock);
    #1;
    ctrl_DIV      = 1'b1;
    data_operandA = 32'd100;
    data_operandB = 32'd5;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    waitRdy(60, lat);
    checkOutput("both latency", W'(lat), 32'd22);
    checkOutput("both result", data_result, 32'd12);
    checkOutput("both exception", W'(data_exception), 32'd0);
    countRdy(40, nRdy);
    checkOutput("both extra rdy", W'(nRdy), 32'd0);

    // Reset mid-divide aborts: outputs clear and no RDY ever follows.
    applyStimulus(1'b0, 1'b1, 32'd100, 32'd7);
    repeat (14) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    checkOutput("abort result", data_result, 32'd0);
    checkOutput("abort exception", W'(data_exception), 32'd0);
    checkOutput("abort busy", W'(busy), 32'd0);
    countRdy(40, nRdy);
    checkOutput("abort rdy", W'(nRdy), 32'd0);

    // Rerun 100 / 7 = 14, then start a new multiply in the very first IDLE
    // cycle after RDY: -5 * -5 = 25.
    runOp("div 100/7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd14, 1'b0, 33);
    runOp("b2b mul", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'd25, 1'b0, 33);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/multdiv_iter_ctrl.md
Name: multdiv_iter_ctrl

Overview:
- Iterative signed multiply/divide unit that acts as the initiator and consumer of an iteration count: it starts an operation, counts down one step per cycle, and reports the result.
- Accepts single-cycle ctrl_MULT/ctrl_DIV start pulses and runs WIDTH shift-add or restoring-divide steps.
- Asserts a one-cycle data_resultRDY with result and exception.
- Sits between decode/stall logic and the register-file writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits (power of two, ≥ 4).
- CNT_W, 5, iteration counter width, equal to clog2(WIDTH).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- ctrl_MULT  input  1  start multiply; sampled only in IDLE.
- ctrl_DIV  input  1  start divide; sampled only in IDLE.
- data_operandA  input  WIDTH  multiplicand/dividend, two's complement; captured with the start pulse.
- data_operandB  input  WIDTH  multiplier/divisor, two's complement; captured with the start pulse.
- data_result  output  WIDTH  product low word, or quotient.
- data_exception  output  1  overflow or divide-by-zero.
- data_resultRDY  output  1  one-cycle result-valid strobe.
- busy  output  1  high from the cycle after capture through the RDY cycle.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: state=IDLE, data_result=0, data_exception=0, data_resultRDY=0, busy=0, counter=0. A reset asserted mid-operation aborts the operation; no RDY is ever produced for it.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - On an edge with ctrl_MULT=1 or ctrl_DIV=1, capture the operands, op, |A|, |B|, and result sign (A[msb]^B[msb]).
  - Load the counter with WIDTH-1 and go to RUN.
  - If both ctrls are high, MULT wins.
  - Divide with B==0: skip RUN, go directly to DONE with exception=1 and result=0.
- RUN:
  - One step per cycle; the counter decrements each cycle.
  - Leave for FIX on the cycle the counter is 0, so RUN lasts exactly WIDTH cycles.
  - MULT step: if the multiplier LSB is 1, add the multiplicand into the 2*WIDTH-bit product high half; then shift right 1.
  - DIV step: shift the {remainder,quotient} pair left 1; trial subtract |B|. If the result is non-negative, keep it and set the quotient LSB, else restore.
  - ctrl_MULT/ctrl_DIV are ignored in RUN, FIX and DONE; they are not queued.
- FIX (one cycle):
  - Apply the sign: negate if the sign flag is set.
  - MULT: result = low WIDTH bits of the signed product. exception=1 if the signed 2*WIDTH product does not sign-extend from bit WIDTH-1.
  - DIV: quotient truncates toward zero. exception=1 only when A = most-negative and B = -1; result is then the most-negative value.
- DONE (one cycle): data_resultRDY=1, then return to IDLE.
  - A new start pulse is accepted on the edge that leaves DONE, i.e. it is sampled in the first IDLE cycle.
- Output hold: data_result and data_exception hold their values until the next DONE or reset.
- Latency: start sampled at edge 0 → RDY high during cycle WIDTH+2 (34 for WIDTH=32). Divide-by-zero → RDY high during cycle 1.
- Arithmetic: multiply uses a WIDTH+1-bit adder; divide uses a WIDTH+1-bit subtractor. The most-negative magnitude is handled by the extra bit.

Decomposition:
- Shared package/defines file:
  - State encodings: IDLE=2'b00, RUN=2'b01, FIX=2'b10, DONE=2'b11.
  - Op codes: OP_MULT=1'b0, OP_DIV=1'b1.
  - Default WIDTH/CNT_W.
- Sub-module iter_down_counter (CNT_W bits):
  - Inputs: clock, reset, load, load_val, en.
  - Outputs: count, zero.
  - Synchronous active-high reset to 0; load has priority over en; no wrap in use.
- The datapath stays in the top module.

Test Plan:
- Reset held 2 cycles, then MULT A=6, B=-7 → RDY exactly 34 cycles after the start edge; result=-42 (0xFFFFFFD6); exception=0; busy low the cycle after RDY.
- MULT A=0x00010000, B=0x00010000 → exception=1, result=0x00000000. Then MULT A=0x80000000, B=1 → exception=0, result=0x80000000.
- DIV A=-43, B=5 → result=-8 (0xFFFFFFF8), exception=0. Then DIV A=0x80000000, B=-1 → exception=1.
- DIV A=7, B=0 → RDY in cycle 1 after the start edge, exception=1, result=0; no RUN cycles occur.
- Start MULT 3×4 with ctrl_DIV pulsed at cycle 10 and ctrl_MULT+ctrl_DIV together at start → only one RDY (result=12, multiply chosen); pulses during busy are ignored.
- Start DIV 100/7, assert reset at cycle 15 for 1 cycle → outputs 0, no RDY. Then start DIV 100/7 → RDY at +34, result=14. Also check a start pulse in the cycle after RDY is accepted.
